// File: rtl/pipeline_stall_sequencer_pkg.sv
// ============================================================================
// Module   : pipeline_stall_sequencer_pkg
// Purpose  : Shared types and constants for the pipeline stall sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_stall_sequencer_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    localparam logic [4:0] c_reg_zero = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_ctrl;
        logic stall_ctrl;
        logic ifid_flush;
        logic idex_flush;
        logic idex_en;
        logic exmem_bubble;
        logic muldiv_done;
    } ctrl_t;

    // Free-flowing pipeline: nothing held, nothing flushed.
    localparam ctrl_t c_ctrl_default = '{
        pc_en: 1'b1, ifid_ctrl: 1'b1, stall_ctrl: 1'b0, ifid_flush: 1'b0,
        idex_flush: 1'b0, idex_en: 1'b1, exmem_bubble: 1'b0, muldiv_done: 1'b0
    };

    // Front end and EX frozen while the mult/div unit owns EX.
    localparam ctrl_t c_ctrl_md_hold = '{
        pc_en: 1'b0, ifid_ctrl: 1'b0, stall_ctrl: 1'b0, ifid_flush: 1'b0,
        idex_flush: 1'b0, idex_en: 1'b0, exmem_bubble: 1'b1, muldiv_done: 1'b0
    };

endpackage

`default_nettype wire

// File: rtl/pipeline_stall_sequencer_load_use_compare.sv
// ============================================================================
// Module   : load_use_compare
// Purpose  : Combinational load-use hazard detector (LW in ID/EX vs IF/ID).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_compare
    import pipeline_stall_sequencer_pkg::*;
(
    input  logic       lw_detected,
    input  logic [4:0] ID_EX_rt,
    input  logic [4:0] IF_ID_rs,
    input  logic [4:0] IF_ID_rt,
    input  logic       IF_ID_uses_rs,
    input  logic       IF_ID_uses_rt,
    input  logic       sw_detected,
    output logic       lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = IF_ID_uses_rs && (ID_EX_rt == IF_ID_rs);
    // Store data of a SW reaches MEM late enough to be forwarded there.
    assign w_rt_hit = IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt) && !sw_detected;
    assign lu       = lw_detected && (ID_EX_rt != c_reg_zero) && (w_rs_hit || w_rt_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_sequencer.sv
// ============================================================================
// Module   : pipeline_stall_sequencer
// Purpose  : Arbitrates load-use stalls, branch flushes and mult/div EX
//            occupancy for a 5-stage MIPS pipeline; counts stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stall_sequencer
    import pipeline_stall_sequencer_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lw_detected,
    input  logic [4:0]       ID_EX_rt,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_uses_rs,
    input  logic             IF_ID_uses_rt,
    input  logic             sw_detected,
    input  logic             branch_taken,
    input  logic             muldiv_start,
    output logic             PC_En,
    output logic             IFID_ctrl,
    output logic             stall_ctrl,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             IDEX_en,
    output logic             EXMEM_bubble,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned MD_W = $clog2(MULDIV_CYCLES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MD_W-1:0]   r_md_cnt;
    logic [MD_W-1:0]   w_md_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic              w_lu;
    ctrl_t             w_ctrl;

    load_use_compare u_load_use_compare (
        .lw_detected   (lw_detected),
        .ID_EX_rt      (ID_EX_rt),
        .IF_ID_rs      (IF_ID_rs),
        .IF_ID_rt      (IF_ID_rt),
        .IF_ID_uses_rs (IF_ID_uses_rs),
        .IF_ID_uses_rt (IF_ID_uses_rt),
        .sw_detected   (sw_detected),
        .lu            (w_lu)
    );

    always_comb begin
        w_ctrl       = c_ctrl_default;
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;

        if (!reset) begin
            w_ctrl       = c_ctrl_default;
            w_state_nxt  = ST_RUN;
            w_md_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken) begin
                        w_ctrl.ifid_flush = 1'b1;
                        w_ctrl.idex_flush = 1'b1;
                    end else if (muldiv_start) begin
                        w_ctrl       = c_ctrl_md_hold;
                        w_md_cnt_nxt = MD_W'(MULDIV_CYCLES - 2);
                        w_state_nxt  = ST_MD_BUSY;
                    end else if (w_lu) begin
                        w_ctrl.pc_en      = 1'b0;
                        w_ctrl.ifid_ctrl  = 1'b0;
                        w_ctrl.stall_ctrl = 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    if (r_md_cnt != '0) begin
                        w_ctrl       = c_ctrl_md_hold;
                        w_md_cnt_nxt = r_md_cnt - MD_W'(1);
                    end else begin
                        // Result cycle: EX advances, a new mult/div cannot start.
                        w_ctrl.muldiv_done = 1'b1;
                        w_state_nxt        = ST_RUN;
                        if (branch_taken) begin
                            w_ctrl.ifid_flush = 1'b1;
                            w_ctrl.idex_flush = 1'b1;
                        end else if (w_lu) begin
                            w_ctrl.pc_en      = 1'b0;
                            w_ctrl.ifid_ctrl  = 1'b0;
                            w_ctrl.stall_ctrl = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_RUN;
            r_md_cnt       <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            if (!w_ctrl.pc_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    assign PC_En        = w_ctrl.pc_en;
    assign IFID_ctrl    = w_ctrl.ifid_ctrl;
    assign stall_ctrl   = w_ctrl.stall_ctrl;
    assign IFID_flush   = w_ctrl.ifid_flush;
    assign IDEX_flush   = w_ctrl.idex_flush;
    assign IDEX_en      = w_ctrl.idex_en;
    assign EXMEM_bubble = w_ctrl.exmem_bubble;
    assign muldiv_done  = w_ctrl.muldiv_done;
    assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_sequencer.sv
// ============================================================================
// Module   : tb_pipeline_stall_sequencer
// Purpose  : Directed self-checking bench for pipeline_stall_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stall_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        lw_detected;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;
    logic        IF_ID_uses_rs;
    logic        IF_ID_uses_rt;
    logic        sw_detected;
    logic        branch_taken;
    logic        muldiv_start;

    logic        PC_En, IFID_ctrl, stall_ctrl, IFID_flush, IDEX_flush;
    logic        IDEX_en, EXMEM_bubble, muldiv_done;
    logic [15:0] stall_cycles;

    logic        s_PC_En, s_IFID_ctrl, s_stall_ctrl, s_IFID_flush, s_IDEX_flush;
    logic        s_IDEX_en, s_EXMEM_bubble, s_muldiv_done;
    logic [3:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    pipeline_stall_sequencer #(.MULDIV_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .lw_detected(lw_detected), .ID_EX_rt(ID_EX_rt),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rs(IF_ID_uses_rs),
        .IF_ID_uses_rt(IF_ID_uses_rt), .sw_detected(sw_detected),
        .branch_taken(branch_taken), .muldiv_start(muldiv_start),
        .PC_En(PC_En), .IFID_ctrl(IFID_ctrl), .stall_ctrl(stall_ctrl),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .IDEX_en(IDEX_en),
        .EXMEM_bubble(EXMEM_bubble), .muldiv_done(muldiv_done),
        .stall_cycles(stall_cycles)
    );

    pipeline_stall_sequencer #(.MULDIV_CYCLES(4), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .lw_detected(lw_detected), .ID_EX_rt(ID_EX_rt),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rs(IF_ID_uses_rs),
        .IF_ID_uses_rt(IF_ID_uses_rt), .sw_detected(sw_detected),
        .branch_taken(branch_taken), .muldiv_start(muldiv_start),
        .PC_En(s_PC_En), .IFID_ctrl(s_IFID_ctrl), .stall_ctrl(s_stall_ctrl),
        .IFID_flush(s_IFID_flush), .IDEX_flush(s_IDEX_flush), .IDEX_en(s_IDEX_en),
        .EXMEM_bubble(s_EXMEM_bubble), .muldiv_done(s_muldiv_done),
        .stall_cycles(s_stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Packs {PC_En,IFID_ctrl,stall_ctrl,IFID_flush,IDEX_flush,IDEX_en,EXMEM_bubble,muldiv_done}
    function automatic logic [7:0] ctl();
        return {PC_En, IFID_ctrl, stall_ctrl, IFID_flush, IDEX_flush,
                IDEX_en, EXMEM_bubble, muldiv_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lw_detected = 0; ID_EX_rt = 0; IF_ID_rs = 0; IF_ID_rt = 0;
        IF_ID_uses_rs = 0; IF_ID_uses_rt = 0; sw_detected = 0;
        branch_taken = 0; muldiv_start = 0;
    endtask

    task automatic set_lu_rs();
        lw_detected = 1; ID_EX_rt = 5'd9; IF_ID_rs = 5'd9; IF_ID_uses_rs = 1;
    endtask

    localparam logic [7:0] CTL_DEF  = 8'b1100_0100;
    localparam logic [7:0] CTL_LU   = 8'b0010_0100;
    localparam logic [7:0] CTL_BR   = 8'b1101_1100;
    localparam logic [7:0] CTL_HOLD = 8'b0000_0010;
    localparam logic [7:0] CTL_DONE = 8'b1100_0101;

    initial begin
        idle_inputs();
        reset = 0;
        // Hazard and mult/div requests during reset must not leak through.
        set_lu_rs();
        muldiv_start = 1;
        #2;
        chk("reset_outputs_forced", ctl(), CTL_DEF);
        tick();
        tick();
        chk("reset_cnt", stall_cycles, 0);
        idle_inputs();
        reset = 1;
        #2;
        chk("run_defaults", ctl(), CTL_DEF);
        tick();

        // Load-use on rs: one bubble, then the LW has moved on.
        set_lu_rs();
        #2;
        chk("lu_rs_stall", ctl(), CTL_LU);
        tick();
        exp_cnt = 1;
        chk("lu_rs_cnt", stall_cycles, exp_cnt);
        lw_detected = 0;
        #2;
        chk("lu_released", ctl(), CTL_DEF);
        tick();
        chk("lu_cnt_hold", stall_cycles, exp_cnt);

        // rt-only match on a SW: no stall; same match on a non-store: stall.
        idle_inputs();
        lw_detected = 1; ID_EX_rt = 5'd9; IF_ID_rt = 5'd9; IF_ID_uses_rt = 1; sw_detected = 1;
        #2;
        chk("sw_rt_no_stall", ctl(), CTL_DEF);
        sw_detected = 0;
        #2;
        chk("rt_stall", ctl(), CTL_LU);
        tick();
        exp_cnt = 2;

        // $zero never creates a hazard.
        idle_inputs();
        lw_detected = 1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_uses_rs = 1;
        #2;
        chk("zero_reg_no_stall", ctl(), CTL_DEF);
        tick();

        // Branch wins over a simultaneous load-use.
        idle_inputs();
        set_lu_rs();
        branch_taken = 1;
        #2;
        chk("branch_over_lu", ctl(), CTL_BR);
        tick();
        chk("branch_cnt", stall_cycles, exp_cnt);

        // Mult/div: start stays high to show it is ignored in MD_BUSY.
        idle_inputs();
        muldiv_start = 1;
        #2;
        chk("md_T", ctl(), CTL_HOLD);
        tick();
        #1;
        chk("md_T1", ctl(), CTL_HOLD);
        tick();
        #1;
        chk("md_T2", ctl(), CTL_HOLD);
        tick();
        #1;
        chk("md_T3_done", ctl(), CTL_DONE);
        tick();
        exp_cnt = 5;
        chk("md_cnt", stall_cycles, exp_cnt);
        muldiv_start = 0;
        #2;
        chk("md_T4_run", ctl(), CTL_DEF);
        tick();

        // Reset during T+1 of a mult/div aborts it without a done pulse.
        muldiv_start = 1;
        #2;
        chk("md2_T", ctl(), CTL_HOLD);
        tick();
        muldiv_start = 0;
        reset = 0;
        #2;
        chk("md2_reset_defaults", ctl(), CTL_DEF);
        tick();
        reset = 1;
        #2;
        chk("md2_after_reset", ctl(), CTL_DEF);
        chk("md2_cnt_cleared", stall_cycles, 0);
        tick();
        #1;
        chk("md2_no_done_T3", ctl(), CTL_DEF);
        tick();
        #1;
        chk("md2_no_done_T4", ctl(), CTL_DEF);
        tick();

        // 20 consecutive stall cycles: 4-bit counter saturates, 16-bit does not.
        set_lu_rs();
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk("sat_small", s_stall_cycles, 15);
        chk("sat_wide", stall_cycles, 20);
        tick();
        chk("sat_small_hold", s_stall_cycles, 15);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
